aes_key_sched_ctrl: RTL

- Sequencer for the single-round AES-128 key-expansion datapath (gen_key plus its clocked S-box lookups).
- On start, loads the cipher key as round key 0 and steps the expansion datapath through rounds 0..9.
- Waits out the datapath latency on each round, then captures each result into an 11-entry round-key store.
- The cipher core reads the store through a synchronous read port once keys_valid is high.

---
 rtl/aes_pkg.sv | 8 +
 rtl/aes_rk_store.sv | 31 +++
 rtl/aes_key_sched_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key schedule constants and sequencer state type
package aes_pkg;
  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_KEY_W      = 128;
  localparam int AES_RK_DEPTH   = 11;

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, DONE} ks_state_t;
endpackage

// File: rtl/aes_rk_store.sv
// rtl/aes_rk_store.sv - 11x128 round-key register file, one write port, registered read port
module aes_rk_store
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [3:0]           waddr,
  input  logic [AES_KEY_W-1:0] wdata,
  input  logic [3:0]           rd_addr,
  output logic [AES_KEY_W-1:0] rd_data
);
  logic [AES_KEY_W-1:0] mem [0:AES_RK_DEPTH-1];

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we && (waddr < 4'(AES_RK_DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_addr < 4'(AES_RK_DEPTH)) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - sequences the external key-expansion datapath and stores all round keys
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KX_LAT     = 1,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_valid,
  output logic [3:0]           kx_round,
  output logic [AES_KEY_W-1:0] kx_key_in,
  input  logic [AES_KEY_W-1:0] kx_key_out,
  input  logic [3:0]           rk_rd_addr,
  output logic [AES_KEY_W-1:0] rk_rd_data
);
  localparam logic [1:0] LAST_WAIT  = (KX_LAT > 0) ? 2'(KX_LAT - 1) : 2'd0;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  // With zero datapath latency every round is a bare capture.
  localparam ks_state_t ROUND_ENTRY = (KX_LAT == 0) ? CAPT : WAIT;

  ks_state_t            state, state_next;
  logic [1:0]           wait_cnt;
  logic                 accept, capt, last_capt;
  logic                 st_we;
  logic [3:0]           st_waddr;
  logic [AES_KEY_W-1:0] st_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capt       = 1'b0;
    last_capt  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ROUND_ENTRY;
        end
      end
      WAIT: begin
        if (wait_cnt == LAST_WAIT) state_next = CAPT;
      end
      CAPT: begin
        capt = 1'b1;
        if (kx_round == LAST_ROUND) begin
          last_capt  = 1'b1;
          state_next = DONE;
        end else begin
          state_next = ROUND_ENTRY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      kx_round   <= '0;
      kx_key_in  <= '0;
      wait_cnt   <= '0;
    end else begin
      done <= last_capt;
      if (accept) begin
        kx_key_in  <= key_in;
        kx_round   <= '0;
        wait_cnt   <= '0;
        keys_valid <= 1'b0;
        busy       <= 1'b1;
      end else if (capt) begin
        kx_key_in <= kx_key_out;
        wait_cnt  <= '0;
        if (last_capt) begin
          busy       <= 1'b0;
          keys_valid <= 1'b1;
        end else begin
          kx_round <= kx_round + 4'd1;
        end
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end
    end
  end

  assign st_we    = accept | capt;
  assign st_waddr = accept ? 4'd0 : kx_round + 4'd1;
  assign st_wdata = accept ? key_in : kx_key_out;

  aes_rk_store u_store (
    .clk     (clk),
    .rst     (rst),
    .we      (st_we),
    .waddr   (st_waddr),
    .wdata   (st_wdata),
    .rd_addr (rk_rd_addr),
    .rd_data (rk_rd_data)
  );
endmodule
